branch_resolver: RTL

- EX-stage companion to the IF-stage branch predictor: evaluates the real outcome of every branch/jump and registers the feedback bundle the predictor consumes (correct next pc, branch pc, predicted/actual bits, table-update strobe).
- Raises flush on misprediction, then squashes wrong-path instructions for a fixed shadow window.
- Keeps saturating branch and mispredict counters for performance reporting.

---
 rtl/branch_resolver_if.sv | 39 +++
 rtl/branch_resolver.sv | 135 +++++++++++++
 2 files changed

// File: rtl/branch_resolver_if.sv
// EX-stage resolve bus: instruction operands in, predictor feedback and perf counters out.
interface branch_resolver_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic              stall;
    logic              in_valid;
    logic              in_branch;
    logic              in_predict;
    logic              in_ujtype;
    logic [2:0]        in_funct3;
    logic [DATA_W-1:0] in_pc;
    logic [DATA_W-1:0] in_imm;
    logic [DATA_W-1:0] in_rs1;
    logic [DATA_W-1:0] in_rs2;
    logic              in_pred_taken;
    logic [DATA_W-1:0] out_target;
    logic [DATA_W-1:0] out_branch_pc;
    logic              out_predict;
    logic              out_actual;
    logic              out_branch;
    logic              flush;
    logic [CNT_W-1:0]  br_count;
    logic [CNT_W-1:0]  miss_count;

    modport master (
        output stall, in_valid, in_branch, in_predict, in_ujtype, in_funct3,
               in_pc, in_imm, in_rs1, in_rs2, in_pred_taken,
        input  out_target, out_branch_pc, out_predict, out_actual, out_branch,
               flush, br_count, miss_count
    );

    modport slave (
        input  stall, in_valid, in_branch, in_predict, in_ujtype, in_funct3,
               in_pc, in_imm, in_rs1, in_rs2, in_pred_taken,
        output out_target, out_branch_pc, out_predict, out_actual, out_branch,
               flush, br_count, miss_count
    );
endinterface

// File: rtl/branch_resolver.sv
// Resolves branch/jump outcomes in EX, registers predictor feedback, and squashes
// the wrong-path shadow after a mispredict.
module branch_resolver #(
    parameter int DATA_W      = 32,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    branch_resolver_if.slave   bus
);
    typedef enum logic {NORMAL, SHADOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [2:0]       SHADOW_LOAD = 3'(FLUSH_DEPTH);

    state_t            state, state_nx;
    logic [2:0]        shadow_cnt, shadow_cnt_nx;

    logic              cond;
    logic              res_actual, res_predict, res_branch;
    logic [DATA_W-1:0] res_target;
    logic [DATA_W-1:0] seq_pc, rel_pc, jalr_sum;
    logic              accept, is_cond, mispredict;

    logic [DATA_W-1:0] target_q, branch_pc_q;
    logic              predict_q, actual_q, branch_q;
    logic [CNT_W-1:0]  br_cnt_q, miss_cnt_q;

    assign seq_pc   = bus.in_pc + DATA_W'(4);
    assign rel_pc   = bus.in_pc + bus.in_imm;
    assign jalr_sum = bus.in_rs1 + bus.in_imm;

    always_comb begin
        cond = 1'b0;
        case (bus.in_funct3)
            3'b000:  cond = (bus.in_rs1 == bus.in_rs2);
            3'b001:  cond = (bus.in_rs1 != bus.in_rs2);
            3'b100:  cond = ($signed(bus.in_rs1) <  $signed(bus.in_rs2));
            3'b101:  cond = ($signed(bus.in_rs1) >= $signed(bus.in_rs2));
            3'b110:  cond = (bus.in_rs1 <  bus.in_rs2);
            3'b111:  cond = (bus.in_rs1 >= bus.in_rs2);
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        res_actual  = 1'b0;
        res_predict = 1'b0;
        res_branch  = 1'b0;
        res_target  = seq_pc;
        if (bus.in_branch) begin
            if (bus.in_predict) begin
                res_actual  = cond;
                res_predict = bus.in_pred_taken;
                res_branch  = 1'b1;
                res_target  = cond ? rel_pc : seq_pc;
            end else begin
                // Unconditional jumps are always "predicted" taken, so they never flush.
                res_actual  = 1'b1;
                res_predict = 1'b1;
                res_target  = bus.in_ujtype ? rel_pc : {jalr_sum[DATA_W-1:1], 1'b0};
            end
        end
    end

    assign accept     = bus.in_valid && !bus.stall && (state == NORMAL);
    assign is_cond    = bus.in_branch && bus.in_predict;
    assign mispredict = accept && (res_predict != res_actual);

    always_comb begin
        state_nx      = state;
        shadow_cnt_nx = shadow_cnt;
        if (!bus.stall) begin
            case (state)
                NORMAL: if (mispredict) begin
                    state_nx      = SHADOW;
                    shadow_cnt_nx = SHADOW_LOAD;
                end
                SHADOW: begin
                    shadow_cnt_nx = shadow_cnt - 3'd1;
                    if (shadow_cnt == 3'd1) state_nx = NORMAL;
                end
                default: state_nx = NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= NORMAL;
            shadow_cnt <= '0;
        end else begin
            state      <= state_nx;
            shadow_cnt <= shadow_cnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target_q    <= '0;
            branch_pc_q <= '0;
            predict_q   <= 1'b0;
            actual_q    <= 1'b0;
            branch_q    <= 1'b0;
            br_cnt_q    <= '0;
            miss_cnt_q  <= '0;
        end else if (!bus.stall) begin
            if (accept) begin
                target_q    <= res_target;
                branch_pc_q <= bus.in_pc;
                predict_q   <= res_predict;
                actual_q    <= res_actual;
                branch_q    <= res_branch;
            end else begin
                target_q    <= '0;
                branch_pc_q <= '0;
                predict_q   <= 1'b0;
                actual_q    <= 1'b0;
                branch_q    <= 1'b0;
            end
            if (accept && is_cond && br_cnt_q != CNT_MAX) br_cnt_q <= br_cnt_q + CNT_W'(1);
            if (mispredict && miss_cnt_q != CNT_MAX)      miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
    end

    assign bus.out_target    = target_q;
    assign bus.out_branch_pc = branch_pc_q;
    assign bus.out_predict   = predict_q;
    assign bus.out_actual    = actual_q;
    assign bus.out_branch    = branch_q;
    assign bus.flush         = predict_q ^ actual_q;
    assign bus.br_count      = br_cnt_q;
    assign bus.miss_count    = miss_cnt_q;
endmodule
